// File: rtl/clock_pkg.sv
// Shared definitions for the clock/alarm path: editor state encoding, field limits,
// the alarm mode code and the active-high {a..g} seven-segment digit patterns.
package clock_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2
   } alarm_state_t;

   localparam logic [4:0] MAX_HOUR   = 5'd23;
   localparam logic [5:0] MAX_MIN    = 6'd59;
   localparam logic [1:0] MODE_ALARM = 2'd1;

   localparam logic [6:0] SEG_0     = 7'b1111110;
   localparam logic [6:0] SEG_1     = 7'b0110000;
   localparam logic [6:0] SEG_2     = 7'b1101101;
   localparam logic [6:0] SEG_3     = 7'b1111001;
   localparam logic [6:0] SEG_4     = 7'b0110011;
   localparam logic [6:0] SEG_5     = 7'b1011011;
   localparam logic [6:0] SEG_6     = 7'b1011111;
   localparam logic [6:0] SEG_7     = 7'b1110000;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1111011;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

endpackage

// File: rtl/seg7_digit.sv
// One BCD digit to active-high {a..g} segments; blank (or a non-BCD code) lights nothing.
module seg7_digit
   import clock_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (!blank) begin
         case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/alarm_setter.sv
// Alarm time editor: edits shadow hour/minute, commits atomically and drives six digits.
// Define ALARM_SNOOZE_EN to add snooze_req/snooze_active and the original-time registers.
module alarm_setter
   import clock_pkg::*;
#(
   parameter int RESET_HOUR = 7,
   parameter int RESET_MIN  = 0
`ifdef ALARM_SNOOZE_EN
   , parameter int SNOOZE_MIN = 5
`endif
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] currentMode,
   input  logic       real_quarter,
   input  logic       pulsed_set,
   input  logic       pulsed_up,
   input  logic       pulsed_down,
   output logic [4:0] alarm_hours,
   output logic [5:0] alarm_minutes,
   output logic       alarm_enable,
   output logic [1:0] state,
   output logic [6:0] disp0,
   output logic [6:0] disp1,
   output logic [6:0] disp2,
   output logic [6:0] disp3,
   output logic [6:0] disp4,
   output logic [6:0] disp5
`ifdef ALARM_SNOOZE_EN
   , input  logic     snooze_req
   , output logic     snooze_active
`endif
);

   localparam logic [4:0] RST_H = 5'(RESET_HOUR);
   localparam logic [5:0] RST_M = 6'(RESET_MIN);

   alarm_state_t state_q;
   logic [4:0]   shadow_hours;
   logic [5:0]   shadow_minutes;
   logic [4:0]   load_hours;
   logic [5:0]   load_minutes;
   logic         active, do_set, do_up, do_down;

   // set beats a step; up and down together cancel
   assign active  = (currentMode == MODE_ALARM);
   assign do_set  = active & pulsed_set;
   assign do_up   = active & pulsed_up & ~pulsed_down & ~pulsed_set;
   assign do_down = active & pulsed_down & ~pulsed_up & ~pulsed_set;

`ifdef ALARM_SNOOZE_EN
   logic [4:0] orig_hours;
   logic [5:0] orig_minutes;
   logic [6:0] snz_sum;
   logic [4:0] snz_hours;
   logic [5:0] snz_minutes;
   logic       snz_go;

   always_comb begin
      snz_sum     = 7'(alarm_minutes) + 7'(SNOOZE_MIN);
      snz_hours   = alarm_hours;
      snz_minutes = 6'(snz_sum);
      if (snz_sum > 7'(MAX_MIN)) begin
         snz_minutes = 6'(snz_sum - 7'd60);
         snz_hours   = (alarm_hours >= MAX_HOUR) ? 5'd0 : alarm_hours + 5'd1;
      end
   end

   // a snoozed committed time is not what the user set; edits and toggles start from the original
   assign load_hours   = snooze_active ? orig_hours : alarm_hours;
   assign load_minutes = snooze_active ? orig_minutes : alarm_minutes;
   assign snz_go       = snooze_req & alarm_enable;
`else
   assign load_hours   = alarm_hours;
   assign load_minutes = alarm_minutes;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= IDLE;
         alarm_hours    <= RST_H;
         alarm_minutes  <= RST_M;
         shadow_hours   <= RST_H;
         shadow_minutes <= RST_M;
         alarm_enable   <= 1'b0;
`ifdef ALARM_SNOOZE_EN
         orig_hours     <= RST_H;
         orig_minutes   <= RST_M;
         snooze_active  <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (do_set || do_up) begin
                  if (do_set) begin
                     state_q        <= SET_HOUR;
                     shadow_hours   <= load_hours;
                     shadow_minutes <= load_minutes;
                  end else begin
                     alarm_enable <= ~alarm_enable;
                  end
`ifdef ALARM_SNOOZE_EN
                  alarm_hours   <= load_hours;
                  alarm_minutes <= load_minutes;
                  snooze_active <= 1'b0;
`endif
               end
`ifdef ALARM_SNOOZE_EN
               else if (snz_go) begin
                  alarm_hours   <= snz_hours;
                  alarm_minutes <= snz_minutes;
                  snooze_active <= 1'b1;
               end
`endif
            end
            SET_HOUR: begin
               if (!active)      state_q <= IDLE;
               else if (do_set)  state_q <= SET_MIN;
               else if (do_up)   shadow_hours <= (shadow_hours >= MAX_HOUR) ? 5'd0 : shadow_hours + 5'd1;
               else if (do_down) shadow_hours <= (shadow_hours == 5'd0) ? MAX_HOUR : shadow_hours - 5'd1;
            end
            SET_MIN: begin
               if (!active) begin
                  state_q <= IDLE;
               end else if (do_set) begin
                  state_q       <= IDLE;
                  alarm_hours   <= shadow_hours;
                  alarm_minutes <= shadow_minutes;
                  alarm_enable  <= 1'b1;
`ifdef ALARM_SNOOZE_EN
                  orig_hours    <= shadow_hours;
                  orig_minutes  <= shadow_minutes;
                  snooze_active <= 1'b0;
`endif
               end else if (do_up) begin
                  shadow_minutes <= (shadow_minutes >= MAX_MIN) ? 6'd0 : shadow_minutes + 6'd1;
               end else if (do_down) begin
                  shadow_minutes <= (shadow_minutes == 6'd0) ? MAX_MIN : shadow_minutes - 6'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign state = state_q;

   logic       editing, blank_h, blank_m;
   logic [4:0] src_h;
   logic [5:0] src_m;
   logic [3:0] h_tens, h_ones, m_tens, m_ones;

   assign editing = (state_q == SET_HOUR) || (state_q == SET_MIN);
   assign src_h   = editing ? shadow_hours : alarm_hours;
   assign src_m   = editing ? shadow_minutes : alarm_minutes;
   assign h_tens  = 4'(src_h / 5'd10);
   assign h_ones  = 4'(src_h % 5'd10);
   assign m_tens  = 4'(src_m / 6'd10);
   assign m_ones  = 4'(src_m % 6'd10);
   assign blank_h = (state_q == SET_HOUR) & ~real_quarter;
   assign blank_m = (state_q == SET_MIN) & ~real_quarter;

   seg7_digit u_d0 (.bcd(h_tens), .blank(blank_h), .seg(disp0));
   seg7_digit u_d1 (.bcd(h_ones), .blank(blank_h), .seg(disp1));
   seg7_digit u_d2 (.bcd(m_tens), .blank(blank_m), .seg(disp2));
   seg7_digit u_d3 (.bcd(m_ones), .blank(blank_m), .seg(disp3));
   seg7_digit u_d4 (.bcd(4'd0), .blank(1'b1), .seg(disp4));
   seg7_digit u_d5 (.bcd({3'b000, alarm_enable}), .blank(1'b0), .seg(disp5));

endmodule

// File: tb/tb_alarm_setter.sv
// Self-checking bench for alarm_setter: directed scenarios plus random pulses against a time-of-day model.
module tb_alarm_setter;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [1:0] currentMode = 2'd0;
   logic       real_quarter = 1'b1;
   logic       pulsed_set = 1'b0, pulsed_up = 1'b0, pulsed_down = 1'b0;
   logic [4:0] alarm_hours;
   logic [5:0] alarm_minutes;
   logic       alarm_enable;
   logic [1:0] state;
   logic [6:0] disp0, disp1, disp2, disp3, disp4, disp5;
`ifdef ALARM_SNOOZE_EN
   logic       snooze_req = 1'b0;
   logic       snooze_active;
`endif

   alarm_setter dut (
      .clk(clk), .reset_n(reset_n), .currentMode(currentMode), .real_quarter(real_quarter),
      .pulsed_set(pulsed_set), .pulsed_up(pulsed_up), .pulsed_down(pulsed_down),
      .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm_enable(alarm_enable),
      .state(state), .disp0(disp0), .disp1(disp1), .disp2(disp2), .disp3(disp3),
      .disp4(disp4), .disp5(disp5)
`ifdef ALARM_SNOOZE_EN
      , .snooze_req(snooze_req), .snooze_active(snooze_active)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   // reference model: 0 idle, 1 editing hour, 2 editing minute
   int m_state, m_h, m_m, m_en, sh_h, sh_m, m_snz, org_h, org_m, m_rq;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_h = 7; m_m = 0; m_en = 0; sh_h = 7; sh_m = 0;
      m_snz = 0; org_h = 7; org_m = 0;
   endtask

   task automatic restore();
      if (m_snz != 0) begin
         m_h = org_h; m_m = org_m; m_snz = 0;
      end
   endtask

   task automatic model_step(input bit s, input bit u, input bit d, input logic [1:0] mode, input bit snz);
      bit act, ds, du, dd;
      int t;
      act = (mode == 2'd1);
      ds  = act && s;
      du  = act && u && !d && !s;
      dd  = act && d && !u && !s;
      case (m_state)
         0: begin
            if (ds) begin
               restore(); sh_h = m_h; sh_m = m_m; m_state = 1;
            end else if (du) begin
               restore(); m_en = 1 - m_en;
            end else if (snz && m_en == 1) begin
               t = (m_h * 60 + m_m + 5) % 1440;
               m_h = t / 60; m_m = t % 60; m_snz = 1;
            end
         end
         1: begin
            if (!act) m_state = 0;
            else if (ds) m_state = 2;
            else if (du) sh_h = (sh_h + 1) % 24;
            else if (dd) sh_h = (sh_h + 23) % 24;
         end
         default: begin
            if (!act) m_state = 0;
            else if (ds) begin
               m_h = sh_h; m_m = sh_m; org_h = sh_h; org_m = sh_m; m_en = 1; m_state = 0;
            end
            else if (du) sh_m = (sh_m + 1) % 60;
            else if (dd) sh_m = (sh_m + 59) % 60;
         end
      endcase
   endtask

   task automatic check_all();
      int vh, vm;
      logic [6:0] e0, e1, e2, e3;
      vh = (m_state != 0) ? sh_h : m_h;
      vm = (m_state != 0) ? sh_m : m_m;
      e0 = seg_tab[vh / 10]; e1 = seg_tab[vh % 10];
      e2 = seg_tab[vm / 10]; e3 = seg_tab[vm % 10];
      if (m_state == 1 && m_rq == 0) begin e0 = 7'd0; e1 = 7'd0; end
      if (m_state == 2 && m_rq == 0) begin e2 = 7'd0; e3 = 7'd0; end
      chk("state", state, m_state);
      chk("alarm_hours", alarm_hours, m_h);
      chk("alarm_minutes", alarm_minutes, m_m);
      chk("alarm_enable", alarm_enable, m_en);
      chk("disp0", disp0, e0);
      chk("disp1", disp1, e1);
      chk("disp2", disp2, e2);
      chk("disp3", disp3, e3);
      chk("disp4", disp4, 7'd0);
      chk("disp5", disp5, seg_tab[m_en]);
`ifdef ALARM_SNOOZE_EN
      chk("snooze_active", snooze_active, m_snz);
`endif
   endtask

   // one clock per call: drive at negedge, model steps on the posedge, check 1 time unit later
   task automatic drive(input bit s, input bit u, input bit d, input logic [1:0] mode,
                        input bit rq_v, input bit snz);
      @(negedge clk);
      pulsed_set = s; pulsed_up = u; pulsed_down = d;
      currentMode = mode; real_quarter = rq_v; m_rq = rq_v;
`ifdef ALARM_SNOOZE_EN
      snooze_req = snz;
`endif
      @(posedge clk);
      model_step(s, u, d, mode, snz);
      #1 check_all();
   endtask

   initial begin
      model_reset();
      m_rq = 1;
      repeat (3) @(posedge clk);
      #1 check_all();
      chk("rst_hours", alarm_hours, 5'd7);
      chk("rst_disp1", disp1, 7'b1110000);
      chk("rst_disp0", disp0, 7'b1111110);
      #1 reset_n = 1'b1;

      // 07:00 -> 23:59 through both wraps; committed stays 07:00 until final set
      drive(1, 0, 0, 2'd1, 1, 0);
      for (int i = 0; i < 8; i++) drive(0, 0, 1, 2'd1, 1, 0);
      drive(1, 0, 0, 2'd1, 1, 0);
      drive(0, 0, 1, 2'd1, 1, 0);
      chk("pre_commit_hours", alarm_hours, 5'd7);
      drive(1, 0, 0, 2'd1, 1, 0);
      chk("commit_hours", alarm_hours, 5'd23);
      chk("commit_minutes", alarm_minutes, 6'd59);
      chk("commit_enable", alarm_enable, 1'b1);

      // leave alarm mode mid-edit with shadow minute 30
      drive(1, 0, 0, 2'd1, 1, 0);
      drive(1, 0, 0, 2'd1, 1, 0);
      for (int i = 0; i < 29; i++) drive(0, 0, 1, 2'd1, 1, 0);
      chk("shadow_m30_tens", disp2, 7'b1111001);
      drive(0, 0, 0, 2'd0, 1, 0);
      chk("abort_state", state, 2'd0);
      chk("abort_minutes", alarm_minutes, 6'd59);
      drive(1, 0, 0, 2'd0, 1, 0);
      drive(0, 1, 0, 2'd2, 1, 0);
      drive(0, 0, 1, 2'd3, 1, 0);
      drive(1, 0, 0, 2'd1, 1, 0);
      chk("reload_disp3", disp3, 7'b1111011);

      // simultaneous pulses
      drive(1, 1, 0, 2'd1, 1, 0);
      chk("set_up_state", state, 2'd2);
      chk("set_up_disp1", disp1, 7'b1111001);
      drive(0, 1, 1, 2'd1, 1, 0);
      chk("up_down_disp3", disp3, 7'b1111011);
      drive(1, 0, 0, 2'd1, 1, 0);

      // blink of the hour field
      drive(1, 0, 0, 2'd1, 1, 0);
      drive(0, 0, 0, 2'd1, 0, 0);
      chk("blink_disp0", disp0, 7'd0);
      chk("blink_disp2", disp2, 7'b1011011);
      drive(0, 0, 0, 2'd1, 1, 0);
      chk("vis_disp0", disp0, 7'b1101101);
      drive(0, 0, 0, 2'd0, 1, 0);

      for (int i = 0; i < 500; i++) begin
         logic [1:0] md;
         bit rs;
         md = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
         rs = 1'b0;
`ifdef ALARM_SNOOZE_EN
         rs = ($urandom_range(0, 4) == 0);
`endif
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
               md, $urandom_range(0, 1) == 1, rs);
      end

      // asynchronous reset while editing minutes
      drive(0, 0, 0, 2'd0, 1, 0);
      drive(1, 0, 0, 2'd1, 1, 0);
      drive(1, 0, 0, 2'd1, 1, 0);
      reset_n = 1'b0;
      model_reset();
      #1 check_all();
      #1 reset_n = 1'b1;

`ifdef ALARM_SNOOZE_EN
      drive(1, 0, 0, 2'd1, 1, 0);
      for (int i = 0; i < 8; i++) drive(0, 0, 1, 2'd1, 1, 0);
      drive(1, 0, 0, 2'd1, 1, 0);
      drive(0, 0, 1, 2'd1, 1, 0);
      drive(0, 0, 1, 2'd1, 1, 0);
      drive(1, 0, 0, 2'd1, 1, 0);
      drive(0, 0, 0, 2'd1, 1, 1);
      chk("snz_hours", alarm_hours, 5'd0);
      chk("snz_minutes", alarm_minutes, 6'd3);
      chk("snz_active", snooze_active, 1'b1);
      drive(0, 1, 0, 2'd1, 1, 0);
      chk("unsnz_enable", alarm_enable, 1'b0);
      chk("unsnz_hours", alarm_hours, 5'd23);
      chk("unsnz_minutes", alarm_minutes, 6'd58);
      chk("unsnz_active", snooze_active, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
